// File: rtl/arith_pkg.sv
// arith_pkg: shared declarations for the Lab 2 arithmetic datapath.
//   add_serial_state_t : FSM state encoding of add_serial
//   ADD_SERIAL_N_DEF   : default operand width of add_serial
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } add_serial_state_t;

    localparam int unsigned ADD_SERIAL_N_DEF = 4;

endpackage

// File: rtl/sum_1.sv
// sum_1: 1-bit full adder.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : majority(a, b, cin)
module sum_1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/add_serial.sv
// add_serial: bit-serial N-bit adder, one bit per clock, LSB first, using a
// single sum_1 full-adder cell. A start seen in IDLE captures a, b and cin;
// N RUN cycles later the result is registered and done pulses for one cycle.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : request, only sampled in IDLE
//   a, b, cin      : operands and carry-in, captured on the accepted start edge
//   busy           : high while bits are being processed
//   done           : one-cycle pulse, results valid from this cycle on
//   sum, cout      : (a + b + cin) mod 2^N and carry out of bit N-1, held until
//                    the next completion
//   ovf            : two's-complement overflow; present only when the macro
//                    ADD_SERIAL_OVF_EN is defined
module add_serial
    import arith_pkg::*;
#(
    parameter int unsigned N = ADD_SERIAL_N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef ADD_SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    add_serial_state_t state;
    logic [N-1:0]      a_sh;
    logic [N-1:0]      b_sh;
    // Holds the N-1 sum bits produced so far; the current full-adder bit
    // completes the word, so the final shift never needs a storage slot.
    logic [N-2:0]      acc;
    logic              c;
    logic [CntW-1:0]   cnt;
    logic              fa_s;
    logic              fa_co;
    logic [N-1:0]      acc_next;

    sum_1 u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .sum  (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        acc_next = {fa_s, acc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
`ifdef ADD_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_sh  <= a;
                        b_sh  <= b;
                        acc   <= '0;
                        c     <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    acc  <= acc_next[N-1:1];
                    c    <= fa_co;
                    if (cnt == CntLast) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= acc_next;
                        cout  <= fa_co;
`ifdef ADD_SERIAL_OVF_EN
                        // c is the carry into the MSB on this last bit.
                        ovf   <= c ^ fa_co;
`endif
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_serial.sv
// tb_add_serial: self-checking bench for add_serial (N = 4). Inputs are driven
// and outputs sampled on the falling clock edge. Expected results come from
// plain integer arithmetic on the operands. ovf is checked only when
// ADD_SERIAL_OVF_EN is defined.
module tb_add_serial;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
`ifdef ADD_SERIAL_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [N-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;
    logic         exp_ovf  = 1'b0;

    add_serial #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef ADD_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: unsigned sum split into result and carry, signed sum for ovf.
    function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                  input logic mc);
        int total;
        int sa;
        int sb;
        int st;
        total = int'(ma) + int'(mb) + int'(mc);
        sa = (int'(ma) >= (1 << (N - 1))) ? int'(ma) - (1 << N) : int'(ma);
        sb = (int'(mb) >= (1 << (N - 1))) ? int'(mb) - (1 << N) : int'(mb);
        st = sa + sb + int'(mc);
        exp_sum  = N'(total % (1 << N));
        exp_cout = (total >= (1 << N));
        exp_ovf  = (st > (1 << (N - 1)) - 1) || (st < -(1 << (N - 1)));
    endfunction

    task automatic check_results(input string tag);
        check_eq({tag, ".sum"}, 32'(sum), 32'(exp_sum));
        check_eq({tag, ".cout"}, 32'(cout), 32'(exp_cout));
`ifdef ADD_SERIAL_OVF_EN
        check_eq({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // Issue one operation from IDLE, scramble the inputs after the start edge,
    // and return on the falling edge just after the done cycle.
    task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc,
                         input string tag);
        int cycles;
        start = 1'b1;
        a     = ta;
        b     = tb;
        cin   = tc;
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = N'($urandom);
        cin   = ~tc;
        cycles = 1;
        while (!done && cycles < int'(N) + 6) begin
            check_eq({tag, ".busy"}, 32'(busy), 32'd1);
            check_eq({tag, ".held"}, 32'(sum), 32'(exp_sum));
            @(negedge clk);
            cycles++;
        end
        check_eq({tag, ".latency"}, 32'(cycles), 32'(N + 1));
        model(ta, tb, tc);
        check_eq({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check_results(tag);
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int gap;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.done", 32'(done), 32'd0);
        check_results("rst");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_op(4'd7, 4'd5, 1'b0, "d7p5");
        do_op(4'hF, 4'h1, 1'b0, "dFp1");
        do_op(4'hF, 4'hF, 1'b1, "dFpFc");
        do_op(4'd3, 4'd4, 1'b0, "capture");

        // Back-to-back: start in the cycle right after done.
        do_op(4'd2, 4'd2, 1'b0, "b2b");

        // start held high: one op every N+2 cycles, each giving 7.
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd4;
        cin   = 1'b0;
        done_cnt   = 0;
        first_done = 0;
        gap        = 0;
        for (int k = 1; k <= 4 * int'(N + 2); k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                check_eq("hold.sum", 32'(sum), 32'd7);
                if (done_cnt == 1) first_done = k;
                else if (done_cnt == 2) gap = k - first_done;
            end
            if (k == 2 * int'(N + 2)) start = 1'b0;
        end
        check_eq("hold.first_latency", 32'(first_done), 32'(N + 1));
        check_eq("hold.done_count", 32'(done_cnt), 32'd2);
        check_eq("hold.spacing", 32'(gap), 32'(N + 2));
        model(4'd3, 4'd4, 1'b0);

        // Reset two cycles into RUN discards the operation.
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        check_eq("midrst.busy", 32'(busy), 32'd0);
        check_results("midrst");
        done_cnt = 0;
        for (int k = 0; k < int'(N + 4); k++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check_eq("midrst.no_done", 32'(done_cnt), 32'd0);
        do_op(4'd9, 4'd6, 1'b1, "after_rst");

        // rst and start on the same edge: rst wins.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        check_eq("rst_start.busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("rst_start.busy2", 32'(busy), 32'd0);

        // Random operations with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            do_op(N'($urandom), N'($urandom), 1'($urandom), "rand");
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
